// File: rtl/secuenciador_cafetera_if.sv
// Signal bundle between the user-selection logic, the recipe-time mux and the valve sequencer.
// Latency: none (wires only); the sequencer registers every output it drives.
// Backpressure: none; start is a level and is simply ignored while the sequencer is busy.
// Optional macro PAUSE_EN adds the pausa input.
interface secuenciador_cafetera_if;
    logic       start;
    logic       cancel;
    logic [2:0] sel_in;
    logic [2:0] sel_out;
    logic [1:0] t_agua;
    logic [1:0] t_cafe;
    logic [1:0] t_leche;
    logic [1:0] t_chocolate;
    logic [1:0] t_azucar;
    logic       v_agua;
    logic       v_cafe;
    logic       v_leche;
    logic       v_chocolate;
    logic       v_azucar;
    logic [2:0] paso;
    logic       busy;
    logic       done;
    logic       error;
`ifdef PAUSE_EN
    logic       pausa;
`endif

    // Requester side: selection logic plus the recipe-time mux.
    modport master (
`ifdef PAUSE_EN
        output pausa,
`endif
        output start, cancel, sel_in,
        output t_agua, t_cafe, t_leche, t_chocolate, t_azucar,
        input  sel_out, v_agua, v_cafe, v_leche, v_chocolate, v_azucar,
        input  paso, busy, done, error
    );

    // Sequencer side.
    modport slave (
`ifdef PAUSE_EN
        input  pausa,
`endif
        input  start, cancel, sel_in,
        input  t_agua, t_cafe, t_leche, t_chocolate, t_azucar,
        output sel_out, v_agua, v_cafe, v_leche, v_chocolate, v_azucar,
        output paso, busy, done, error
    );
endinterface

// File: rtl/secuenciador_cafetera.sv
// Runs one drink recipe: latches the drink code, captures five times, opens the valves in order.
// Latency: start sampled at E0 gives the first valve high after E2; each skipped zero-time step adds 1 cycle.
// Backpressure: start ignored while busy; cancel aborts LOAD/EVAL/RUN. Optional macro PAUSE_EN adds pausa.
module secuenciador_cafetera #(
    parameter int TICKS = 50000000
) (
    input logic                  clk,
    input logic                  rst,
    secuenciador_cafetera_if.slave bus
);
    localparam int PW = (TICKS > 1) ? $clog2(TICKS) : 1;
    localparam logic [PW-1:0] PRE_MAX = PW'(TICKS - 1);

    typedef enum logic [2:0] {IDLE, LOAD, EVAL, RUN, FIN} state_t;

    state_t          state_q, state_d;
    logic [2:0]      sel_q, sel_d;
    logic [2:0]      paso_q, paso_d;
    logic [4:0][1:0] tiempo_q, tiempo_d;
    logic [1:0]      unid_q, unid_d;
    logic [PW-1:0]   pre_q, pre_d;
    logic            abierta_q, abierta_d;
    logic [4:0]      valv_q, valv_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            error_q, error_d;
    logic [1:0]      t_act;
    logic            pausa_w;

`ifdef PAUSE_EN
    assign pausa_w = bus.pausa;
`else
    assign pausa_w = 1'b0;
`endif

    // Time of the step currently addressed by paso.
    always_comb begin
        t_act = 2'd0;
        case (paso_q)
            3'd0:    t_act = tiempo_q[0];
            3'd1:    t_act = tiempo_q[1];
            3'd2:    t_act = tiempo_q[2];
            3'd3:    t_act = tiempo_q[3];
            3'd4:    t_act = tiempo_q[4];
            default: t_act = 2'd0;
        endcase
    end

    // Next-state and next-output computation for the recipe sequencer.
    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        paso_d   = paso_q;
        tiempo_d = tiempo_q;
        unid_d   = unid_q;
        pre_d    = pre_q;
        error_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    sel_d   = bus.sel_in;
                    paso_d  = 3'd0;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                tiempo_d[0] = bus.t_agua;
                tiempo_d[1] = bus.t_cafe;
                tiempo_d[2] = bus.t_leche;
                tiempo_d[3] = bus.t_chocolate;
                tiempo_d[4] = bus.t_azucar;
                if ((bus.t_agua | bus.t_cafe | bus.t_leche | bus.t_chocolate | bus.t_azucar) == 2'd0) begin
                    error_d = 1'b1;
                    state_d = IDLE;
                end else begin
                    state_d = EVAL;
                end
            end
            EVAL: begin
                if (t_act == 2'd0) begin
                    if (paso_q < 3'd4) begin
                        paso_d = paso_q + 3'd1;
                    end else begin
                        state_d = FIN;
                    end
                end else begin
                    unid_d  = t_act;
                    pre_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                // Count only cycles in which the valve was actually open, so a
                // pause never eats into the programmed time.
                if (abierta_q) begin
                    if (pre_q == PRE_MAX) begin
                        pre_d = '0;
                        if (unid_q == 2'd1) begin
                            unid_d = 2'd0;
                            if (paso_q < 3'd4) begin
                                paso_d  = paso_q + 3'd1;
                                state_d = EVAL;
                            end else begin
                                state_d = FIN;
                            end
                        end else begin
                            unid_d = unid_q - 2'd1;
                        end
                    end else begin
                        pre_d = pre_q + 1'b1;
                    end
                end
            end
            FIN: begin
                paso_d  = 3'd0;
                state_d = IDLE;
            end
            default: begin
                paso_d  = 3'd0;
                state_d = IDLE;
            end
        endcase

        // Abort wins over every transition of an active recipe.
        if (bus.cancel && (state_q == LOAD || state_q == EVAL || state_q == RUN)) begin
            state_d = IDLE;
            paso_d  = 3'd0;
            error_d = 1'b0;
        end

        // Valve opens the cycle RUN is entered; in RUN a sampled pausa closes it.
        abierta_d = (state_d == RUN) && !(state_q == RUN && pausa_w);
        valv_d    = abierta_d ? (5'b00001 << paso_d) : 5'b00000;
        busy_d    = (state_d != IDLE);
        done_d    = (state_d == FIN);
    end

    // State and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            sel_q     <= 3'd0;
            paso_q    <= 3'd0;
            tiempo_q  <= '0;
            unid_q    <= 2'd0;
            pre_q     <= '0;
            abierta_q <= 1'b0;
            valv_q    <= 5'b00000;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            paso_q    <= paso_d;
            tiempo_q  <= tiempo_d;
            unid_q    <= unid_d;
            pre_q     <= pre_d;
            abierta_q <= abierta_d;
            valv_q    <= valv_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            error_q   <= error_d;
        end
    end

    assign bus.sel_out     = sel_q;
    assign bus.paso        = paso_q;
    assign bus.v_agua      = valv_q[0];
    assign bus.v_cafe      = valv_q[1];
    assign bus.v_leche     = valv_q[2];
    assign bus.v_chocolate = valv_q[3];
    assign bus.v_azucar    = valv_q[4];
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.error       = error_q;
endmodule
